// File: rtl/reg_file_sb.sv
// Register file with two combinational read ports, one clocked write port,
// write-through bypass and a per-register busy scoreboard for hazard checks.
module reg_file_sb #(
   parameter int DATA_W  = 8,
   parameter int ADDR_W  = 3,
   parameter int ZERO_R0 = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] read1,
   input  logic [ADDR_W-1:0] read2,
   output logic [DATA_W-1:0] reg1,
   output logic [DATA_W-1:0] reg2,
   output logic              busy1,
   output logic              busy2,
   input  logic              write_reg,
   input  logic [ADDR_W-1:0] write_addr,
   input  logic [DATA_W-1:0] write_data,
   input  logic              issue,
   input  logic [ADDR_W-1:0] issue_addr,
   output logic              any_busy
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic HARD_ZERO = (ZERO_R0 != 0);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  busy;
   logic [DEPTH-1:0]  set_vec;
   logic [DEPTH-1:0]  clr_vec;
   logic              write_ok;
   logic              hit1;
   logic              hit2;

   assign write_ok = write_reg && !(HARD_ZERO && (write_addr == '0));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (HARD_ZERO && (i == 0))
               mem[i] <= '0;
            else
               mem[i] <= DATA_W'(i);
         end
      end else if (write_ok) begin
         mem[write_addr] <= write_data;
      end
   end

   // A newer issue supersedes a retiring writeback, so set takes priority.
   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      for (int i = 0; i < DEPTH; i++) begin
         set_vec[i] = issue && (issue_addr == ADDR_W'(i)) && !(HARD_ZERO && (i == 0));
         clr_vec[i] = write_reg && (write_addr == ADDR_W'(i));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         busy <= '0;
      else
         busy <= (busy & ~clr_vec) | set_vec;
   end

   assign hit1 = write_reg && (write_addr == read1);
   assign hit2 = write_reg && (write_addr == read2);

   always_comb begin
      reg1 = mem[read1];
      if (HARD_ZERO && (read1 == '0))
         reg1 = '0;
      else if (hit1)
         reg1 = write_data;
   end

   always_comb begin
      reg2 = mem[read2];
      if (HARD_ZERO && (read2 == '0))
         reg2 = '0;
      else if (hit2)
         reg2 = write_data;
   end

   // A same-cycle writeback already satisfies the operand through the bypass.
   assign busy1    = busy[read1] && !hit1;
   assign busy2    = busy[read2] && !hit2;
   assign any_busy = |busy;

endmodule

// File: tb/tb_reg_file_sb.sv
// Randomised and directed bench for reg_file_sb against a behavioural model
// of the register file contents and the pending-register set.
module tb_reg_file_sb;

   logic       clk;
   logic       rst;
   logic [2:0] read1;
   logic [2:0] read2;
   logic [7:0] reg1;
   logic [7:0] reg2;
   logic       busy1;
   logic       busy2;
   logic       write_reg;
   logic [2:0] write_addr;
   logic [7:0] write_data;
   logic       issue;
   logic [2:0] issue_addr;
   logic       any_busy;

   int checks = 0;
   int failures = 0;

   int model_mem [8];
   bit model_busy [8];

   reg_file_sb #(.DATA_W(8), .ADDR_W(3), .ZERO_R0(1)) dut (
      .clk(clk), .rst(rst),
      .read1(read1), .read2(read2),
      .reg1(reg1), .reg2(reg2),
      .busy1(busy1), .busy2(busy2),
      .write_reg(write_reg), .write_addr(write_addr), .write_data(write_data),
      .issue(issue), .issue_addr(issue_addr),
      .any_busy(any_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
      end
   endtask

   function automatic void modelReset();
      for (int i = 0; i < 8; i++) begin
         model_mem[i]  = i;
         model_busy[i] = 1'b0;
      end
      model_mem[0] = 0;
   endfunction

   function automatic int expReg(input int addr);
      if (addr == 0) return 0;
      if (write_reg && int'(write_addr) == addr) return int'(write_data);
      return model_mem[addr];
   endfunction

   function automatic int expBusy(input int addr);
      if (write_reg && int'(write_addr) == addr) return 0;
      return model_busy[addr] ? 1 : 0;
   endfunction

   function automatic int expAny();
      for (int i = 0; i < 8; i++)
         if (model_busy[i]) return 1;
      return 0;
   endfunction

   task automatic checkAll(input string tag);
      checkOutput({tag, ".reg1"},  32'(reg1),     32'(expReg(int'(read1))));
      checkOutput({tag, ".reg2"},  32'(reg2),     32'(expReg(int'(read2))));
      checkOutput({tag, ".busy1"}, 32'(busy1),    32'(expBusy(int'(read1))));
      checkOutput({tag, ".busy2"}, 32'(busy2),    32'(expBusy(int'(read2))));
      checkOutput({tag, ".any"},   32'(any_busy), 32'(expAny()));
   endtask

   // Drive one cycle's inputs shortly after an edge and check the settled outputs.
   task automatic applyStimulus(input string tag, input logic wr, input logic [2:0] waddr,
                                input logic [7:0] wdata, input logic iss, input logic [2:0] iaddr,
                                input logic [2:0] r1, input logic [2:0] r2);
      write_reg  = wr;
      write_addr = waddr;
      write_data = wdata;
      issue      = iss;
      issue_addr = iaddr;
      read1      = r1;
      read2      = r2;
      #2;
      checkAll(tag);
   endtask

   task automatic clockEdge();
      @(posedge clk);
      if (write_reg && write_addr != 3'd0) model_mem[write_addr] = int'(write_data);
      if (write_reg) model_busy[write_addr] = 1'b0;
      if (issue && issue_addr != 3'd0) model_busy[issue_addr] = 1'b1;
      #1;
   endtask

   task automatic idle(input string tag, input logic [2:0] r1, input logic [2:0] r2);
      applyStimulus(tag, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, r1, r2);
   endtask

   initial begin
      rst = 1'b1;
      modelReset();
      write_reg = 1'b0; write_addr = '0; write_data = '0;
      issue = 1'b0; issue_addr = '0;
      read1 = 3'd5; read2 = 3'd0;
      #2;
      checkOutput("rst.reg1", 32'(reg1), 32'h05);
      checkOutput("rst.reg2", 32'(reg2), 32'h00);
      checkOutput("rst.busy", 32'({busy1, busy2, any_busy}), 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle("post_rst", 3'd5, 3'd0);
      checkOutput("post_rst.reg1", 32'(reg1), 32'h05);
      clockEdge();

      applyStimulus("bypass", 1'b1, 3'd3, 8'hA7, 1'b0, 3'd0, 3'd3, 3'd1);
      checkOutput("bypass.reg1", 32'(reg1), 32'hA7);
      clockEdge();
      idle("stored", 3'd3, 3'd3);
      checkOutput("stored.reg1", 32'(reg1), 32'hA7);
      clockEdge();

      applyStimulus("r0_wr", 1'b1, 3'd0, 8'hFF, 1'b1, 3'd0, 3'd0, 3'd0);
      checkOutput("r0_wr.reg1", 32'(reg1), 32'h0);
      checkOutput("r0_wr.busy", 32'({busy1, any_busy}), 32'h0);
      clockEdge();
      idle("r0_after", 3'd0, 3'd0);
      checkOutput("r0_after.reg1", 32'(reg1), 32'h0);
      checkOutput("r0_after.busy", 32'({busy1, any_busy}), 32'h0);
      clockEdge();

      applyStimulus("sb_issue", 1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 3'd1, 3'd4);
      checkOutput("sb_issue.busy2", 32'(busy2), 32'h0);
      clockEdge();
      idle("sb_k1", 3'd1, 3'd4);
      checkOutput("sb_k1.busy2", 32'(busy2), 32'h1);
      clockEdge();
      idle("sb_k2", 3'd1, 3'd4);
      clockEdge();
      applyStimulus("sb_wb", 1'b1, 3'd4, 8'h3C, 1'b0, 3'd0, 3'd1, 3'd4);
      checkOutput("sb_wb.busy2", 32'(busy2), 32'h0);
      checkOutput("sb_wb.reg2", 32'(reg2), 32'h3C);
      clockEdge();
      idle("sb_after", 3'd1, 3'd4);
      checkOutput("sb_after.busy2", 32'(busy2), 32'h0);
      checkOutput("sb_after.any", 32'(any_busy), 32'h0);
      clockEdge();

      applyStimulus("sbc_pre", 1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 3'd6, 3'd6);
      clockEdge();
      applyStimulus("sbc_both", 1'b1, 3'd6, 8'h11, 1'b1, 3'd6, 3'd6, 3'd2);
      clockEdge();
      idle("sbc_after", 3'd6, 3'd6);
      checkOutput("sbc_after.reg1", 32'(reg1), 32'h11);
      checkOutput("sbc_after.busy1", 32'(busy1), 32'h1);
      clockEdge();

      applyStimulus("ar_setup", 1'b1, 3'd2, 8'h55, 1'b1, 3'd2, 3'd2, 3'd6);
      clockEdge();
      idle("ar_pre", 3'd2, 3'd6);
      checkOutput("ar_pre.reg1", 32'(reg1), 32'h55);
      checkOutput("ar_pre.busy1", 32'(busy1), 32'h1);
      rst = 1'b1;
      modelReset();
      #1;
      checkOutput("ar_now.reg1", 32'(reg1), 32'h02);
      checkOutput("ar_now.busy1", 32'(busy1), 32'h0);
      checkAll("ar_now");
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle("ar_release", 3'd2, 3'd7);
      clockEdge();

      for (int n = 0; n < 400; n++) begin
         applyStimulus("rand",
                       1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
                       1'($urandom_range(0, 9) < 4), 3'($urandom_range(0, 7)),
                       3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
         clockEdge();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
